// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory port sequencer.
package mem_seq_pkg;

    // Sequencer states: idle/beat 0, second beat of a wide access, read response
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        RESP  = 2'd2
    } seq_state_t;

    // Width of one memory beat (half of the data-side bus)
    localparam int HALF_W = 16;

    // Upper half of a narrow load result
    localparam logic [HALF_W-1:0] ZEXT_HI = '0;

endpackage

// File: rtl/mem_port_sequencer.sv
// Arbiter/sequencer sharing one 16-bit synchronous memory port between
// instruction fetch and the MEM stage. Data wins over fetch; 32-bit data
// accesses are split into two beats and the pipeline is stalled until done.
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = HALF_W
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_grant,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_data,
    input  logic                d_req,
    input  logic                d_write,
    input  logic                d_wide,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [2*DATA_W-1:0] d_wdata,
    output logic [2*DATA_W-1:0] d_rdata,
    output logic                d_done,
    output logic                stall,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    seq_state_t        state_reg;
    logic              write_reg;
    logic              wide_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;
    logic              if_valid_reg;

    // Access sequencing: latch the request at beat 0, capture the first read beat
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            write_reg    <= 1'b0;
            wide_reg     <= 1'b0;
            addr_reg     <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            if_valid_reg <= 1'b0;
        end else begin
            if_valid_reg <= if_grant;
            case (state_reg)
                IDLE: begin
                    if (d_req) begin
                        write_reg <= d_write;
                        wide_reg  <= d_wide;
                        addr_reg  <= d_addr;
                        hi_reg    <= d_wdata[2*DATA_W-1:DATA_W];
                        if (d_wide)
                            state_reg <= BEAT1;
                        else if (!d_write)
                            state_reg <= RESP;
                    end
                end
                BEAT1: begin
                    if (write_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        lo_reg    <= mem_rdata;
                        state_reg <= RESP;
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Memory port mux, fetch grant and completion; all strobes are held low in reset
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = if_addr;
        mem_wdata = '0;
        if_grant  = 1'b0;
        d_done    = 1'b0;
        d_rdata   = '0;
        if (!Reset) begin
            case (state_reg)
                IDLE: begin
                    if (d_req) begin
                        mem_en    = 1'b1;
                        mem_we    = d_write;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata[DATA_W-1:0];
                        d_done    = d_write & ~d_wide;
                    end else if (if_req) begin
                        mem_en   = 1'b1;
                        if_grant = 1'b1;
                    end
                end
                BEAT1: begin
                    mem_en    = 1'b1;
                    mem_we    = write_reg;
                    mem_addr  = addr_reg + ADDR_W'(1);
                    mem_wdata = hi_reg;
                    d_done    = write_reg;
                end
                RESP: begin
                    d_done   = 1'b1;
                    d_rdata  = wide_reg ? {mem_rdata, lo_reg}
                                        : {DATA_W'(ZEXT_HI), mem_rdata};
                    mem_en   = if_req;
                    if_grant = if_req;
                end
                default: ;
            endcase
        end
    end

    assign stall    = d_req & ~d_done;
    assign if_valid = if_valid_reg;
    assign if_data  = mem_rdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a behavioural synchronous memory.
module tb_mem_port_sequencer;

    logic        clk;
    logic        Reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_grant;
    logic        if_valid;
    logic [15:0] if_data;
    logic        d_req;
    logic        d_write;
    logic        d_wide;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem_model [0:65535];

    int n_cmp;
    int n_err;

    mem_port_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
        .if_valid(if_valid), .if_data(if_data),
        .d_req(d_req), .d_write(d_write), .d_wide(d_wide),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory, read data one cycle after issue
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mem_rdata = '0;
        for (int i = 0; i < 65536; i++) mem_model[i] = '0;
        mem_model[16'h0000] = 16'h7000;
        mem_model[16'h0001] = 16'h7001;
        mem_model[16'h0002] = 16'h7002;
        mem_model[16'h0020] = 16'h1111;
        mem_model[16'h0021] = 16'h2222;
        mem_model[16'h0030] = 16'h3333;

        // Reset with requests asserted: strobes must stay low
        Reset = 1'b1; if_req = 1'b1; if_addr = 16'h0005;
        d_req = 1'b1; d_write = 1'b1; d_wide = 1'b0; d_addr = 16'h0077; d_wdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_en",   32'(mem_en),   32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_if_grant", 32'(if_grant), 32'd0);
        chk("rst_d_done",   32'(d_done),   32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_d_rdata",  d_rdata,       32'd0);
        @(negedge clk);
        Reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_write = 1'b0;

        // Narrow write 0xBEEF @ 0x0010: completes in cycle 0, no stall
        @(negedge clk);
        d_req = 1'b1; d_write = 1'b1; d_wide = 1'b0; d_addr = 16'h0010; d_wdata = 32'h0000_BEEF;
        #1;
        chk("nw_mem_en",    32'(mem_en),    32'd1);
        chk("nw_mem_we",    32'(mem_we),    32'd1);
        chk("nw_mem_addr",  32'(mem_addr),  32'h0010);
        chk("nw_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("nw_d_done",    32'(d_done),    32'd1);
        chk("nw_stall",     32'(stall),     32'd0);
        @(negedge clk);
        d_req = 1'b0; d_write = 1'b0;
        #1;
        chk("nw_memory",    32'(mem_model[16'h0010]), 32'hBEEF);

        // Wide read @ 0x0020: beats in cycles 0,1; result in cycle 2
        @(negedge clk);
        d_req = 1'b1; d_write = 1'b0; d_wide = 1'b1; d_addr = 16'h0020;
        #1;
        chk("wr_c0_addr",  32'(mem_addr), 32'h0020);
        chk("wr_c0_we",    32'(mem_we),   32'd0);
        chk("wr_c0_stall", 32'(stall),    32'd1);
        chk("wr_c0_done",  32'(d_done),   32'd0);
        @(negedge clk);
        d_addr = 16'h0055;  // must be ignored after beat 0
        #1;
        chk("wr_c1_en",    32'(mem_en),   32'd1);
        chk("wr_c1_addr",  32'(mem_addr), 32'h0021);
        chk("wr_c1_stall", 32'(stall),    32'd1);
        chk("wr_c1_done",  32'(d_done),   32'd0);
        @(negedge clk);
        #1;
        chk("wr_c2_done",  32'(d_done),   32'd1);
        chk("wr_c2_stall", 32'(stall),    32'd0);
        chk("wr_c2_rdata", d_rdata,       32'h2222_1111);
        @(negedge clk);
        d_req = 1'b0; d_wide = 1'b0;

        // Fetch-only stream 0,1,2: grant every cycle, data one cycle later
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0000;
        #1;
        chk("f0_grant", 32'(if_grant), 32'd1);
        chk("f0_addr",  32'(mem_addr), 32'h0000);
        chk("f0_we",    32'(mem_we),   32'd0);
        @(negedge clk);
        if_addr = 16'h0001;
        #1;
        chk("f1_grant", 32'(if_grant), 32'd1);
        chk("f1_valid", 32'(if_valid), 32'd1);
        chk("f1_data",  32'(if_data),  32'h7000);
        @(negedge clk);
        if_addr = 16'h0002;
        #1;
        chk("f2_grant", 32'(if_grant), 32'd1);
        chk("f2_valid", 32'(if_valid), 32'd1);
        chk("f2_data",  32'(if_data),  32'h7001);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("f3_grant", 32'(if_grant), 32'd0);
        chk("f3_valid", 32'(if_valid), 32'd1);
        chk("f3_data",  32'(if_data),  32'h7002);
        @(negedge clk);
        #1;
        chk("f4_valid", 32'(if_valid), 32'd0);

        // Data and fetch together: data wins, fetch granted in RESP
        @(negedge clk);
        d_req = 1'b1; d_write = 1'b0; d_wide = 1'b0; d_addr = 16'h0030;
        if_req = 1'b1; if_addr = 16'h0002;
        #1;
        chk("arb_c0_grant", 32'(if_grant), 32'd0);
        chk("arb_c0_addr",  32'(mem_addr), 32'h0030);
        chk("arb_c0_stall", 32'(stall),    32'd1);
        @(negedge clk);
        #1;
        chk("arb_c1_done",  32'(d_done),   32'd1);
        chk("arb_c1_rdata", d_rdata,       32'h0000_3333);
        chk("arb_c1_grant", 32'(if_grant), 32'd1);
        chk("arb_c1_addr",  32'(mem_addr), 32'h0002);
        chk("arb_c1_stall", 32'(stall),    32'd0);
        @(negedge clk);
        d_req = 1'b0; if_req = 1'b0;
        #1;
        chk("arb_c2_valid", 32'(if_valid), 32'd1);
        chk("arb_c2_data",  32'(if_data),  32'h7002);

        // Wide write @ 0xFFFF: second beat wraps to 0x0000
        @(negedge clk);
        d_req = 1'b1; d_write = 1'b1; d_wide = 1'b1; d_addr = 16'hFFFF; d_wdata = 32'hAAAA_5555;
        #1;
        chk("ww_c0_we",    32'(mem_we),    32'd1);
        chk("ww_c0_addr",  32'(mem_addr),  32'hFFFF);
        chk("ww_c0_wdata", 32'(mem_wdata), 32'h5555);
        chk("ww_c0_done",  32'(d_done),    32'd0);
        chk("ww_c0_stall", 32'(stall),     32'd1);
        @(negedge clk);
        #1;
        chk("ww_c1_we",    32'(mem_we),    32'd1);
        chk("ww_c1_addr",  32'(mem_addr),  32'h0000);
        chk("ww_c1_wdata", 32'(mem_wdata), 32'hAAAA);
        chk("ww_c1_done",  32'(d_done),    32'd1);
        chk("ww_c1_stall", 32'(stall),     32'd0);
        @(negedge clk);
        d_req = 1'b0; d_write = 1'b0; d_wide = 1'b0;
        #1;
        chk("ww_mem_ffff", 32'(mem_model[16'hFFFF]), 32'h5555);
        chk("ww_mem_0000", 32'(mem_model[16'h0000]), 32'hAAAA);

        // Reset during BEAT1 of a wide write aborts the second beat
        @(negedge clk);
        d_req = 1'b1; d_write = 1'b1; d_wide = 1'b1; d_addr = 16'h0040; d_wdata = 32'h9999_8888;
        #1;
        chk("ab_c0_addr", 32'(mem_addr), 32'h0040);
        chk("ab_c0_done", 32'(d_done),   32'd0);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("ab_rst_en",   32'(mem_en), 32'd0);
        chk("ab_rst_we",   32'(mem_we), 32'd0);
        chk("ab_rst_done", 32'(d_done), 32'd0);
        @(negedge clk);
        Reset = 1'b0; d_req = 1'b0; d_write = 1'b0; d_wide = 1'b0;
        if_req = 1'b1; if_addr = 16'h0001;
        #1;
        chk("ab_idle_grant", 32'(if_grant), 32'd1);
        chk("ab_done",       32'(d_done),   32'd0);
        chk("ab_stall",      32'(stall),    32'd0);
        chk("ab_mem_0040",   32'(mem_model[16'h0040]), 32'h8888);
        chk("ab_mem_0041",   32'(mem_model[16'h0041]), 32'h0000);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("ab_fetch_data", 32'(if_data), 32'h7001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
